// File: rtl/branch_predictor.sv
// Direct-mapped BTB branch predictor with per-entry saturating counters,
// optional gshare index hashing and saturating performance counters.
module branch_predictor #(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 16,
    parameter int TAG_BITS    = 8,
    parameter int CTR_BITS    = 2,
    parameter int GHR_BITS    = 0,
    parameter int CNT_BITS    = 32
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [XLEN-1:0]                           pc_f,
    output logic                                      pred_taken_f,
    output logic [XLEN-1:0]                           pred_target_f,
    input  logic                                      upd_valid,
    input  logic [XLEN-1:0]                           upd_pc,
    input  logic                                      upd_is_jump,
    input  logic                                      upd_taken,
    input  logic [XLEN-1:0]                           upd_target,
    input  logic                                      upd_mispred,
    output logic [((GHR_BITS > 0) ? GHR_BITS : 1)-1:0] ghr_o,
    output logic [CNT_BITS-1:0]                       lookups_o,
    output logic [CNT_BITS-1:0]                       mispreds_o
);

    localparam int IDX = $clog2(BTB_ENTRIES);
    localparam int GW  = (GHR_BITS > 0) ? GHR_BITS : 1;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;

    logic                valid_q  [BTB_ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [BTB_ENTRIES];
    logic [XLEN-1:0]     target_q [BTB_ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [BTB_ENTRIES];
    logic                jmp_q    [BTB_ENTRIES];
    logic [GW-1:0]       ghr_q;
    logic [CNT_BITS-1:0] lookups_q;
    logic [CNT_BITS-1:0] mispreds_q;

    logic [IDX-1:0]      ghrHash;
    logic [IDX-1:0]      fIdx;
    logic [IDX-1:0]      uIdx;
    logic [TAG_BITS-1:0] fTag;
    logic [TAG_BITS-1:0] uTag;
    logic                fHit;
    logic                uHit;
    logic [CTR_BITS-1:0] uCtr_d;
    logic                unusedBits;

    // History is zero-extended into the index; bimodal mode hashes with zero
    generate
        if (GHR_BITS > 0) begin : gHash
            assign ghrHash = IDX'(ghr_q);
        end else begin : gNoHash
            assign ghrHash = '0;
        end
    endgenerate

    assign fIdx = pc_f[IDX-1:0] ^ ghrHash;
    assign uIdx = upd_pc[IDX-1:0] ^ ghrHash;
    assign fTag = pc_f[IDX+TAG_BITS-1:IDX];
    assign uTag = upd_pc[IDX+TAG_BITS-1:IDX];

    // Upper PC bits beyond the tag never participate in lookup
    assign unusedBits = ^{pc_f, upd_pc};

    // Fetch-side lookup: reads registered state only, so same-cycle updates are not visible
    always_comb begin
        fHit          = valid_q[fIdx] && (tag_q[fIdx] == fTag);
        pred_taken_f  = fHit && (jmp_q[fIdx] || ctr_q[fIdx][CTR_BITS-1]);
        pred_target_f = pred_taken_f ? target_q[fIdx] : '0;
    end

    // Saturating counter step for a conditional branch that hits
    always_comb begin
        uHit   = valid_q[uIdx] && (tag_q[uIdx] == uTag);
        uCtr_d = ctr_q[uIdx];
        if (upd_taken) begin
            if (ctr_q[uIdx] != CTR_MAX) uCtr_d = ctr_q[uIdx] + 1'b1;
        end else begin
            if (ctr_q[uIdx] != '0) uCtr_d = ctr_q[uIdx] - 1'b1;
        end
    end

    // BTB training, global history shift and performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
                jmp_q[i]    <= 1'b0;
            end
            ghr_q      <= '0;
            lookups_q  <= '0;
            mispreds_q <= '0;
        end else if (upd_valid) begin
            if (uHit) begin
                if (upd_is_jump) begin
                    ctr_q[uIdx] <= CTR_MAX;
                    jmp_q[uIdx] <= 1'b1;
                end else begin
                    ctr_q[uIdx] <= uCtr_d;
                end
                if (upd_taken) target_q[uIdx] <= upd_target;
            end else if (upd_taken) begin
                valid_q[uIdx]  <= 1'b1;
                tag_q[uIdx]    <= uTag;
                target_q[uIdx] <= upd_target;
                jmp_q[uIdx]    <= upd_is_jump;
                ctr_q[uIdx]    <= upd_is_jump ? CTR_MAX : CTR_WEAK;
            end
            if ((GHR_BITS > 0) && !upd_is_jump) ghr_q <= GW'({ghr_q, upd_taken});
            if (lookups_q != CNT_MAX) lookups_q <= lookups_q + 1'b1;
            if (upd_mispred && (mispreds_q != CNT_MAX)) mispreds_q <= mispreds_q + 1'b1;
        end
    end

    assign ghr_o      = ghr_q;
    assign lookups_o  = lookups_q;
    assign mispreds_o = mispreds_q;

endmodule
